// File: rtl/riscv_config_pkg.sv
// Build-time configuration shared by the L1 memory subsystem.
package riscv_config;

    // Number of L1 requesters sharing the Avalon-MM master (legal 2..4).
    localparam int L1_NUM_REQ = 4;

endpackage : riscv_config

// File: rtl/riscv_types_pkg.sv
// Shared types for the L1 arbiter: FSM state encoding and the latched request.
package riscv_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } l1_arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rnw;
        logic [3:0]  be;
        logic [2:0]  size;
    } l1_arb_request_t;

    // Beats in a read burst: size field is beats minus one, so 1..8.
    function automatic logic [3:0] beat_total(input logic [2:0] size);
        return {1'b0, size} + 4'd1;
    endfunction

endpackage : riscv_types

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches from the index after last_ptr, wrapping,
// so the previous grantee has lowest priority.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    requests,
    input  logic [IDXW-1:0] last_ptr,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [IDXW-1:0] cand;

    // Walk candidates from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int off = N; off >= 1; off--) begin
            cand = IDXW'((int'(last_ptr) + off) % N);
            if (requests[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/l1_avalon_arbiter.sv
// Arbitrates NUM_REQ L1 requesters onto one Avalon-MM master, one
// transaction in flight. Reads may be bursts of up to 8 beats; read data
// is returned on a shared bus with a one-hot strobe to the owner.
// Handshake: req_ack pulses for one cycle in the cycle a request is taken;
// an Avalon beat completes in any ISSUE cycle with avm_waitrequest low;
// each avm_readdatavalid seen in ISSUE/DRAIN produces one rtn_data_valid
// pulse the following cycle.
module l1_avalon_arbiter
    import riscv_types::*;
#(
    parameter int NUM_REQ = riscv_config::L1_NUM_REQ
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_request,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_rnw,
    input  logic [NUM_REQ*4-1:0]  req_be,
    input  logic [NUM_REQ*3-1:0]  req_size,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [31:0]           rtn_data,
    output logic [NUM_REQ-1:0]    rtn_data_valid,
    output logic [31:0]           avm_addr,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [3:0]            avm_byteenable,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid,
    output l1_arb_state_t         dbg_state
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDXW-1:0] RR_RESET = IDXW'(NUM_REQ - 1);

    l1_arb_state_t   state_q, state_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] owner_q, owner_d;
    l1_arb_request_t req_q, req_d;
    logic [3:0]      beat_q, beat_d;
    logic [3:0]      rtn_cnt_q, rtn_cnt_d;
    logic [31:0]     rtn_data_q, rtn_data_d;
    logic [NUM_REQ-1:0] rtn_valid_q, rtn_valid_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [IDXW-1:0]    grant_idx;
    logic               grant_valid;
    l1_arb_request_t    sel_req;
    logic               rtn_hit;

    rr_arbiter #(
        .N    (NUM_REQ),
        .IDXW (IDXW)
    ) u_rr (
        .requests    (req_request),
        .last_ptr    (rr_ptr_q),
        .grant       (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Pick the granted requester's fields out of the flattened buses.
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_req.addr = req_addr[i*32 +: 32];
                sel_req.data = req_data[i*32 +: 32];
                sel_req.rnw  = req_rnw[i];
                sel_req.be   = req_be[i*4 +: 4];
                sel_req.size = req_size[i*3 +: 3];
            end
        end
    end

    // Next-state, grant and return-path logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        req_d       = req_q;
        beat_d      = beat_q;
        rtn_cnt_d   = rtn_cnt_q;
        rtn_data_d  = rtn_data_q;
        rtn_valid_d = '0;
        req_ack     = '0;

        // Returns only count while a read is outstanding; stale data in IDLE is dropped.
        rtn_hit = (state_q != IDLE) && req_q.rnw && avm_readdatavalid;
        if (rtn_hit) begin
            rtn_data_d           = avm_readdata;
            rtn_valid_d[owner_q] = 1'b1;
            rtn_cnt_d            = rtn_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (grant_valid && !rst) begin
                    req_ack   = grant_oh;
                    rr_ptr_d  = grant_idx;
                    owner_d   = grant_idx;
                    req_d     = sel_req;
                    beat_d    = '0;
                    rtn_cnt_d = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!avm_waitrequest) begin
                    if (!req_q.rnw) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                        if (beat_q == {1'b0, req_q.size}) begin
                            state_d = (rtn_cnt_d == beat_total(req_q.size)) ? IDLE : DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (rtn_cnt_d == beat_total(req_q.size)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= RR_RESET;
            owner_q     <= '0;
            req_q       <= '0;
            beat_q      <= '0;
            rtn_cnt_q   <= '0;
            rtn_data_q  <= '0;
            rtn_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            req_q       <= req_d;
            beat_q      <= beat_d;
            rtn_cnt_q   <= rtn_cnt_d;
            rtn_data_q  <= rtn_data_d;
            rtn_valid_q <= rtn_valid_d;
        end
    end

    // Avalon master drive: word address advances per beat, wrapping in 30 bits.
    always_comb begin
        avm_read       = (state_q == ISSUE) && req_q.rnw;
        avm_write      = (state_q == ISSUE) && !req_q.rnw;
        avm_addr       = {req_q.addr[31:2] + 30'(beat_q), 2'b00};
        avm_byteenable = req_q.rnw ? 4'hF : req_q.be;
        avm_writedata  = req_q.data;
    end

    assign rtn_data       = rtn_data_q;
    assign rtn_data_valid = rtn_valid_q;
    assign dbg_state      = state_q;

endmodule : l1_avalon_arbiter

// File: tb/tb_l1_avalon_arbiter.sv
// Directed bench for l1_avalon_arbiter with an Avalon slave model and a
// queue-based scoreboard checked by an independent monitor.
module tb_l1_avalon_arbiter;
    import riscv_types::*;

    localparam int N = 4;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_request;
    logic [N*32-1:0]   req_addr;
    logic [N*32-1:0]   req_data;
    logic [N-1:0]      req_rnw;
    logic [N*4-1:0]    req_be;
    logic [N*3-1:0]    req_size;
    logic [N-1:0]      req_ack;
    logic [31:0]       rtn_data;
    logic [N-1:0]      rtn_data_valid;
    logic [31:0]       avm_addr;
    logic              avm_read;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;
    l1_arb_state_t     dbg_state;

    l1_avalon_arbiter #(.NUM_REQ(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_request       (req_request),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .req_rnw           (req_rnw),
        .req_be            (req_be),
        .req_size          (req_size),
        .req_ack           (req_ack),
        .rtn_data          (rtn_data),
        .rtn_data_valid    (rtn_data_valid),
        .avm_addr          (avm_addr),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int vec_cnt = 0;
    int err_cnt = 0;
    logic [3:0]  exp_ack_q[$];
    logic [68:0] exp_beat_q[$];   // {rnw, byteenable, addr, writedata}
    logic [35:0] exp_rtn_q[$];    // {one-hot owner, data}

    // slave model configuration
    int wait_cfg = 0;
    int rd_lat   = 2;
    bit          pv[8];
    logic [31:0] pa[8];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [71:0] act);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s_unexpected: got %h expected nothing", name, act);
    endtask

    task automatic push_ack(input logic [3:0] oh);
        exp_ack_q.push_back(oh);
    endtask

    task automatic push_beat(input logic rnw, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        exp_beat_q.push_back({rnw, be, a, d});
    endtask

    task automatic push_rtn(input logic [3:0] oh, input logic [31:0] d);
        exp_rtn_q.push_back({oh, d});
    endtask

    function automatic bit pipe_busy();
        for (int k = 0; k < 8; k++) if (pv[k]) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        bit rdv_prev;
        rdv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (req_ack != '0) begin
                if (exp_ack_q.size() == 0) unexpected("ack", 72'(req_ack));
                else check("ack", 72'(req_ack), 72'(exp_ack_q.pop_front()));
            end
            if ((avm_read || avm_write) && !avm_waitrequest) begin
                if (exp_beat_q.size() == 0)
                    unexpected("beat", 72'({avm_read, avm_byteenable, avm_addr, avm_writedata}));
                else
                    check("beat", 72'({avm_read, avm_byteenable, avm_addr, avm_writedata}),
                          72'(exp_beat_q.pop_front()));
            end
            if (rtn_data_valid != '0) begin
                check("rtn_latency", 72'(rdv_prev), 72'(1));
                if (exp_rtn_q.size() == 0) unexpected("rtn", 72'({rtn_data_valid, rtn_data}));
                else check("rtn", 72'({rtn_data_valid, rtn_data}), 72'(exp_rtn_q.pop_front()));
            end
            rdv_prev = avm_readdatavalid;
        end
    end

    // ---------------- Avalon slave model ----------------
    initial begin : avm_slave
        bit busy_prev, acc_prev, acc_rd;
        logic [31:0] a_prev;
        int wcnt;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'h0;
        for (int k = 0; k < 8; k++) begin
            pv[k] = 1'b0;
            pa[k] = 32'h0;
        end
        busy_prev = 1'b0;
        acc_prev  = 1'b0;
        acc_rd    = 1'b0;
        a_prev    = 32'h0;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            busy_prev = avm_read || avm_write;
            acc_prev  = busy_prev && !avm_waitrequest;
            acc_rd    = avm_read && !avm_waitrequest;
            a_prev    = avm_addr;
            @(posedge clk);
            #1;
            for (int k = 7; k > 0; k--) begin
                pv[k] = pv[k-1];
                pa[k] = pa[k-1];
            end
            pv[0] = acc_rd;
            pa[0] = a_prev;
            avm_readdatavalid = pv[rd_lat-1];
            avm_readdata      = pv[rd_lat-1] ? {16'hD0D0, pa[rd_lat-1][15:0]} : 32'h0;
            if (busy_prev && !acc_prev) wcnt++;
            else wcnt = 0;
            avm_waitrequest = (avm_read || avm_write) && (wcnt < wait_cfg);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] d,
                           input logic rnw, input logic [3:0] be, input logic [2:0] sz);
        req_addr[idx*32 +: 32] = a;
        req_data[idx*32 +: 32] = d;
        req_rnw[idx]           = rnw;
        req_be[idx*4 +: 4]     = be;
        req_size[idx*3 +: 3]   = sz;
        req_request[idx]       = 1'b1;
    endtask

    task automatic wait_acks(input int n, input bit drop);
        int seen = 0;
        int cyc  = 0;
        logic [3:0] a;
        while (seen < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            a = req_ack;
            if (a != '0) begin
                seen++;
                if (drop) begin
                    @(posedge clk);
                    #1;
                    req_request = req_request & ~a;
                end
            end
        end
        check("ack_count", 72'(seen), 72'(n));
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            done = (dbg_state == IDLE) && (exp_ack_q.size() == 0) && (exp_beat_q.size() == 0)
                   && (exp_rtn_q.size() == 0) && !pipe_busy();
        end
        check({name, "_pending"}, 72'(exp_ack_q.size() + exp_beat_q.size() + exp_rtn_q.size()), 72'd0);
        check({name, "_idle"}, 72'(dbg_state), 72'(IDLE));
        exp_ack_q.delete();
        exp_beat_q.delete();
        exp_rtn_q.delete();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int cnt;
        int cyc;
        rst         = 1'b1;
        req_request = '1;
        req_addr    = '0;
        req_data    = '0;
        req_rnw     = '0;
        req_be      = '0;
        req_size    = '0;

        // Reset state, with all requests raised to show acks are held off.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 72'(req_ack), 72'd0);
        check("rst_rtn_valid", 72'(rtn_data_valid), 72'd0);
        check("rst_rtn_data", 72'(rtn_data), 72'd0);
        check("rst_read", 72'(avm_read), 72'd0);
        check("rst_write", 72'(avm_write), 72'd0);
        check("rst_addr", 72'(avm_addr), 72'd0);
        check("rst_be", 72'(avm_byteenable), 72'd0);
        check("rst_wdata", 72'(avm_writedata), 72'd0);
        check("rst_state", 72'(dbg_state), 72'(IDLE));
        req_request = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single write with two waitrequest cycles.
        wait_cfg = 2;
        rd_lat   = 2;
        push_ack(4'b0001);
        push_beat(1'b0, 4'b0011, 32'h0000_0100, 32'h0000_A5A5);
        @(posedge clk);
        #1;
        set_req(0, 32'h0000_0100, 32'h0000_A5A5, 1'b0, 4'b0011, 3'd0);
        wait_acks(1, 1'b1);
        cnt = 0;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (avm_write) cnt++;
            else if (cnt > 0) break;
        end
        check("wr_hold_cycles", 72'(cnt), 72'd3);
        check("wr_then_idle", 72'(dbg_state), 72'(IDLE));
        wait_idle("t1_write");

        // Four-beat read burst from requester 1, unaligned start address.
        wait_cfg = 0;
        rd_lat   = 2;
        push_ack(4'b0010);
        push_beat(1'b1, 4'hF, 32'h0000_0200, 32'h0);
        push_beat(1'b1, 4'hF, 32'h0000_0204, 32'h0);
        push_beat(1'b1, 4'hF, 32'h0000_0208, 32'h0);
        push_beat(1'b1, 4'hF, 32'h0000_020C, 32'h0);
        push_rtn(4'b0010, 32'hD0D0_0200);
        push_rtn(4'b0010, 32'hD0D0_0204);
        push_rtn(4'b0010, 32'hD0D0_0208);
        push_rtn(4'b0010, 32'hD0D0_020C);
        @(posedge clk);
        #1;
        set_req(1, 32'h0000_0203, 32'h0, 1'b1, 4'h0, 3'd3);
        wait_acks(1, 1'b1);
        wait_idle("t2_burst");

        // Address wrap across the top of the 32-bit space.
        push_ack(4'b0100);
        push_beat(1'b1, 4'hF, 32'hFFFF_FFFC, 32'h0);
        push_beat(1'b1, 4'hF, 32'h0000_0000, 32'h0);
        push_rtn(4'b0100, 32'hD0D0_FFFC);
        push_rtn(4'b0100, 32'hD0D0_0000);
        @(posedge clk);
        #1;
        set_req(2, 32'hFFFF_FFFC, 32'h0, 1'b1, 4'h0, 3'd1);
        wait_acks(1, 1'b1);
        wait_idle("t3_wrap");

        // Fairness: everyone requests continuously after a reset.
        pulse_reset();
        push_ack(4'b0001);
        push_beat(1'b0, 4'b0001, 32'h0000_1000, 32'hF000_0000);
        push_ack(4'b0010);
        push_beat(1'b0, 4'b0010, 32'h0000_1010, 32'hF000_0001);
        push_ack(4'b0100);
        push_beat(1'b0, 4'b0100, 32'h0000_1020, 32'hF000_0002);
        push_ack(4'b1000);
        push_beat(1'b0, 4'b1000, 32'h0000_1030, 32'hF000_0003);
        push_ack(4'b0001);
        push_beat(1'b0, 4'b0001, 32'h0000_1000, 32'hF000_0000);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            set_req(i, 32'h0000_1000 + 32'(i * 16), 32'hF000_0000 | 32'(i), 1'b0, 4'(1 << i), 3'd0);
        wait_acks(5, 1'b0);
        @(posedge clk);
        #1;
        req_request = '0;
        wait_idle("t4_fair");

        // Reset in the middle of a read burst; late returns must be dropped.
        rd_lat = 4;
        push_ack(4'b0010);
        push_beat(1'b1, 4'hF, 32'h0000_0300, 32'h0);
        push_beat(1'b1, 4'hF, 32'h0000_0304, 32'h0);
        @(posedge clk);
        #1;
        set_req(1, 32'h0000_0300, 32'h0, 1'b1, 4'h0, 3'd3);
        wait_acks(1, 1'b1);
        cnt = 0;
        cyc = 0;
        while (cnt < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (avm_read && !avm_waitrequest) cnt++;
        end
        check("mid_beats_seen", 72'(cnt), 72'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_read_low", 72'(avm_read), 72'd0);
        check("mid_rst_state", 72'(dbg_state), 72'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        wait_idle("t5_drop");

        // First grant after reset goes to requester 0 even with 2 also asking.
        rd_lat = 2;
        push_ack(4'b0001);
        push_beat(1'b0, 4'b1000, 32'h0000_0400, 32'h1234_5678);
        push_ack(4'b0100);
        push_beat(1'b0, 4'b0100, 32'h0000_0500, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        set_req(0, 32'h0000_0400, 32'h1234_5678, 1'b0, 4'b1000, 3'd0);
        set_req(2, 32'h0000_0500, 32'hCAFE_F00D, 1'b0, 4'b0100, 3'd0);
        wait_acks(2, 1'b1);
        wait_idle("t5_regrant");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_l1_avalon_arbiter

// File: doc/l1_avalon_arbiter.md
L1_AVALON_ARBITER -- requirements
Module: l1_avalon_arbiter

Interface
REQ-001 SHALL have parameter: NUM_REQ, 4, number of L1 requesters (legal 2..4).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_request  input  NUM_REQ  per-requester request valid.
REQ-005 SHALL have port: req_addr  input  NUM_REQ x 32  byte address; bits [1:0] ignored.
REQ-006 SHALL have port: req_data  input  NUM_REQ x 32  write data.
REQ-007 SHALL have port: req_rnw  input  NUM_REQ  1 = read, 0 = write.
REQ-008 SHALL have port: req_be  input  NUM_REQ x 4  write byte enables.
REQ-009 SHALL have port: req_size  input  NUM_REQ x 3  read beats minus one (0..7); ignored for writes.
REQ-010 SHALL have port: req_ack  output  NUM_REQ  one-cycle acceptance pulse.
REQ-011 SHALL have port: rtn_data  output  32  shared read-return data.
REQ-012 SHALL have port: rtn_data_valid  output  NUM_REQ  one-hot return strobe.
REQ-013 SHALL have ports: avm_addr out 32; avm_read out 1; avm_write out 1; avm_byteenable out 4; avm_writedata out 32; avm_readdata in 32; avm_waitrequest in 1; avm_readdatavalid in 1 (Avalon-MM master).
REQ-014 Requester ports SHALL be flattened vectors, not interface arrays.

Function
REQ-015 SHALL implement FSM with states IDLE, ISSUE and DRAIN, one transaction in flight.
REQ-016 In IDLE with any req_request set, SHALL grant round-robin, starting at index after last grantee, and assert req_ack[grant] combinationally that cycle.
REQ-017 On grant, SHALL latch addr, data, rnw, be and size of grantee, update RR pointer to grantee, and enter ISSUE next cycle.
REQ-018 In ISSUE, SHALL assert avm_read (rnw=1) or avm_write (rnw=0) continuously; beat accepted on cycle with avm_waitrequest=0.
REQ-019 avm_addr SHALL be {latched_addr[31:2] + beat, 2'b00}; 30-bit add wraps modulo 2^30.
REQ-020 avm_byteenable SHALL be latched be for writes and 4'hF for reads; avm_writedata SHALL be latched data.
REQ-021 A write SHALL be a single beat; on acceptance, SHALL return to IDLE (no response wait).
REQ-022 A read SHALL issue size+1 beats; after last accepted beat, SHALL enter DRAIN, or IDLE if all data already returned.
REQ-023 Each avm_readdatavalid during ISSUE or DRAIN SHALL register avm_readdata to rtn_data and pulse rtn_data_valid[owner] next cycle (latency 1); returns may overlap ISSUE.
REQ-024 DRAIN SHALL exit to IDLE on the cycle return count reaches size+1; the next grant SHALL be possible in the following cycle.
REQ-025 avm_readdatavalid in IDLE SHALL be ignored.
REQ-026 A requester holding req_request after its ack SHALL be treated as a new request and compete in RR.
REQ-027 Beat and return counters SHALL be 4 bits to represent 8 beats without overflow.

Reset
REQ-028 On rst, SHALL asynchronously force IDLE; avm_read, avm_write, req_ack, rtn_data_valid = 0; rtn_data, avm_addr, avm_byteenable, avm_writedata, counters = 0; RR pointer = NUM_REQ-1, so requester 0 has highest priority.
REQ-029 Reset mid-transaction SHALL abandon it; late avm_readdatavalid after reset SHALL be ignored.

Structure
REQ-030 Shared package riscv_types SHALL hold l1_arb_state_t (IDLE/ISSUE/DRAIN) and l1_arb_request_t {addr, data, rnw, be, size}; NUM_REQ default SHALL live in riscv_config.
REQ-031 Round-robin grant SHALL be a sub-module rr_arbiter (inputs requests, last pointer; outputs one-hot grant, index, valid).

Verification
REQ-032 Bench SHALL check single write: req0 write addr 0x100, be 4'b0011, data 0xA5A5, waitrequest 2 cycles -> ack0 one cycle, avm_write held 3 cycles, addr 0x100, be 0011, then IDLE.
REQ-033 Bench SHALL check burst read: req1 read addr 0x203, size 3, no waitrequest, data returned 2 cycles later -> addrs 0x200/204/208/20C, four rtn_data_valid[1] pulses, one cycle after each readdatavalid.
REQ-034 Bench SHALL check fairness: all four requesting continuously with single writes -> grants 0,1,2,3,0 in order.
REQ-035 Bench SHALL check address wrap: read addr 0xFFFFFFFC, size 1 -> avm_addr 0xFFFFFFFC then 0x00000000.
REQ-036 Bench SHALL check reset mid-read: rst asserted after 2 of 4 beats -> avm_read low immediately, later readdatavalid produces no rtn_data_valid, and next grant goes to requester 0.
